// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver, start + DATA_WIDTH data (LSB first) + optional parity + 1 stop.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote around mid-bit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   RX_IN             serial line (idle high), already synchronous to clk
//   PAR_EN, PAR_TYP   parity present / parity type (0 even, 1 odd), captured at frame start
//   Prescale          clocks per bit (even, 8..32)
//   P_DATA            last good payload
//   Data_Valid        1-cycle pulse when P_DATA updates
//   Par_err, Stp_err  1-cycle error pulses
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_err,
    output logic                  Stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  bit_val;
    logic                  exp_par;

    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;
    logic               bit_end;

    assign half    = {1'b0, Prescale[PRESC_W-1:1]};
    assign last    = Prescale - PRESC_W'(1);
    assign bit_end = (edge_cnt == last);
    assign exp_par = par_typ_q ? ~^shift_reg : ^shift_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [2:0]         samp;
    logic [PRESC_W-1:0] mid_m1;
    logic [PRESC_W-1:0] mid_p1;

    assign mid_m1 = half - PRESC_W'(1);
    assign mid_p1 = half + PRESC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 3'b111;
        end else if (state != IDLE) begin
            if (edge_cnt == mid_m1) samp[0] <= RX_IN;
            if (edge_cnt == half)   samp[1] <= RX_IN;
            if (edge_cnt == mid_p1) samp[2] <= RX_IN;
        end
    end

    assign bit_val = (samp[0] & samp[1]) |
                     (samp[0] & samp[2]) |
                     (samp[1] & samp[2]);
`else
    logic samp;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 1'b1;
        end else if (state != IDLE && edge_cnt == half) begin
            samp <= RX_IN;
        end
    end

    assign bit_val = samp;
`endif

    // The bit decision (bit_val) is acted on at the bit end, so the
    // shift, parity compare and stop check all happen on the last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        edge_cnt  <= PRESC_W'(1);
                        bit_cnt   <= '0;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (!bit_end) begin
                        edge_cnt <= edge_cnt + PRESC_W'(1);
                    end else begin
                        edge_cnt <= '0;
                        unique case (state)
                            START: begin
                                state <= bit_val ? IDLE : DATA;
                            end
                            DATA: begin
                                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                                bit_cnt   <= bit_cnt + BW'(1);
                                if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                    bit_cnt <= '0;
                                    state   <= par_en_q ? PARITY : STOP;
                                end
                            end
                            PARITY: begin
                                par_bad <= (bit_val != exp_par);
                                state   <= STOP;
                            end
                            default: begin
                                state   <= IDLE;
                                Par_err <= par_bad;
                                Stp_err <= ~bit_val;
                                if (!par_bad && bit_val) begin
                                    Data_Valid <= 1'b1;
                                    P_DATA     <= shift_reg;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table-driven frames plus hand-written glitch,
// back-to-back, mid-frame reset and mid-bit inversion sequences.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_err;
    logic       Stp_err;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dv_n = 0, pe_n = 0, se_n = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;
    always @(negedge clk) begin
        if (Data_Valid) begin dv_n++; dv_cyc = cyc; end
        if (Par_err)    begin pe_n++; pe_cyc = cyc; end
        if (Stp_err)    begin se_n++; se_cyc = cyc; end
    end

    int pass_n = 0;
    int total_n = 0;

    task automatic check(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting now (cycle 0). PAR_EN/PAR_TYP are
    // inverted from cycle 1 on to show they are captured at frame start.
    task automatic drive_frame(input logic [7:0] data, input int p,
                               input bit pen, input bit ptyp,
                               input bit flip, input bit stp,
                               input int glitch, input int max_c,
                               output int st);
        logic bits [0:10];
        int   n;
        n = pen ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        bits[9]  = (ptyp ? ~^data : ^data) ^ flip;
        bits[n - 1] = stp;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        st = cyc;
        for (int c = 0; c < n * p && c < max_c; c++) begin
            RX_IN = bits[c / p];
            if (c == glitch) RX_IN = ~RX_IN;
            if (c == 1) begin
                PAR_EN  = ~pen;
                PAR_TYP = ~ptyp;
            end
            @(posedge clk);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         flip;
        bit         stp;
        int         dv;
        int         pe;
        int         se;
        logic [7:0] pd;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int st, st2, d0, p0, s0, lat;
        logic [7:0] mv_exp;

        vecs[0] = '{8,  1, 0, 8'h0A, 0, 1, 1, 0, 0, 8'h0A, 88};
        vecs[1] = '{16, 0, 0, 8'h08, 0, 1, 1, 0, 0, 8'h08, 160};
        vecs[2] = '{8,  1, 1, 8'h16, 1, 1, 0, 1, 0, 8'h08, 88};
        vecs[3] = '{8,  1, 0, 8'h05, 0, 0, 0, 0, 1, 8'h08, 88};
        vecs[4] = '{8,  1, 0, 8'h05, 0, 1, 1, 0, 0, 8'h05, 88};
        vecs[5] = '{8,  1, 0, 8'h33, 1, 0, 0, 1, 1, 8'h05, 88};
        vecs[6] = '{10, 1, 1, 8'hFF, 0, 1, 1, 0, 0, 8'hFF, 110};
        vecs[7] = '{32, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 320};

        rst = 1'b1; RX_IN = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        step(4);
        check("reset P_DATA", int'(P_DATA), 0);
        check("reset Data_Valid", int'(Data_Valid), 0);
        check("reset Par_err", int'(Par_err), 0);
        check("reset Stp_err", int'(Stp_err), 0);
        RX_IN = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);

        foreach (vecs[i]) begin
            d0 = dv_n; p0 = pe_n; s0 = se_n;
            drive_frame(vecs[i].data, vecs[i].p, vecs[i].pen, vecs[i].ptyp,
                        vecs[i].flip, vecs[i].stp, -1, 1000, st);
            step(3);
            check($sformatf("vec%0d Data_Valid count", i), dv_n - d0, vecs[i].dv);
            check($sformatf("vec%0d Par_err count", i), pe_n - p0, vecs[i].pe);
            check($sformatf("vec%0d Stp_err count", i), se_n - s0, vecs[i].se);
            check($sformatf("vec%0d P_DATA", i), int'(P_DATA), int'(vecs[i].pd));
            lat = vecs[i].dv != 0 ? dv_cyc : (vecs[i].pe != 0 ? pe_cyc : se_cyc);
            check($sformatf("vec%0d latency", i), lat - st, vecs[i].lat);
        end

        // Start-bit glitch: low for 2 cycles only.
        Prescale = 6'd8; PAR_EN = 1'b0;
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        RX_IN = 1'b0;
        step(2);
        RX_IN = 1'b1;
        step(12);
        check("glitch pulses", (dv_n - d0) + (pe_n - p0) + (se_n - s0), 0);
        check("glitch P_DATA hold", int'(P_DATA), 8'h00);
        drive_frame(8'h0F, 8, 0, 0, 0, 1, -1, 1000, st);
        step(3);
        check("after glitch dv count", dv_n - d0, 1);
        check("after glitch latency", dv_cyc - st, 80);
        check("after glitch P_DATA", int'(P_DATA), 8'h0F);

        // Back-to-back frames, then reset in the middle of the third.
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        drive_frame(8'h0F, 8, 1, 0, 0, 1, -1, 1000, st);
        drive_frame(8'h64, 8, 1, 0, 0, 1, -1, 1000, st2);
        check("b2b first latency", dv_cyc - st, 88);
        drive_frame(8'hA5, 8, 1, 0, 0, 1, -1, 44, st);
        check("b2b second latency", dv_cyc - st2, 88);
        check("b2b dv count", dv_n - d0, 2);
        check("b2b P_DATA", int'(P_DATA), 8'h64);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid reset P_DATA", int'(P_DATA), 0);
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        step(100);
        check("mid reset pulses", (dv_n - d0) + (pe_n - p0) + (se_n - s0), 0);
        check("mid reset P_DATA held", int'(P_DATA), 0);
        drive_frame(8'h3C, 8, 1, 1, 0, 1, -1, 1000, st);
        step(3);
        check("recovery dv count", dv_n - d0, 1);
        check("recovery P_DATA", int'(P_DATA), 8'h3C);

        // One-cycle inversion at the centre of data bit 3 (cycle 36).
`ifdef UART_RX_MAJORITY_VOTE_EN
        mv_exp = 8'h5A;
`else
        mv_exp = 8'h52;
`endif
        d0 = dv_n;
        drive_frame(8'h5A, 8, 0, 0, 0, 1, 36, 1000, st);
        step(3);
        check("midbit dv count", dv_n - d0, 1);
        check("midbit P_DATA", int'(P_DATA), int'(mv_exp));

        // Inversion away from the sample window is harmless either way.
        d0 = dv_n;
        drive_frame(8'hC3, 8, 0, 0, 0, 1, 33, 1000, st);
        step(3);
        check("offbit dv count", dv_n - d0, 1);
        check("offbit P_DATA", int'(P_DATA), 8'hC3);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
